layer_output_collector: RTL and testbench
=========================================

# layer_output_collector

Sits directly downstream of a layer of `numNeurons` neuron instances. It captures each neuron's activation when that neuron flags its output valid, then streams the complete activation vector serially over a valid/ready interface, one element per accepted cycle, to feed the next layer's `neuronIn`/`neuronValid` broadcast. While streaming it also computes a signed argmax over the vector, which on the final layer is the classification result.

## Interface
Parameters:
- `numNeurons`, 32: neurons in the producing layer (≥2).
- `dataWidth`, 16: activation width (signed Q6.10 in the default build).
- `idxWidth`, `$clog2(numNeurons)`: index width (derived; do not override).

Ports:
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `clear` input, 1: synchronous re-arm for the next inference; priority below `reset`, above all else.
- `inData` input, `numNeurons*dataWidth`: concatenated neuron outputs, neuron *i* at bits `[i*dataWidth +: dataWidth]`.
- `inValid` input, `numNeurons`: per-neuron output-valid, bit *i* for neuron *i*. May be a pulse or held high.
- `outData` output, `dataWidth`: current stream element.
- `outValid` output, 1: stream element valid.
- `outReady` input, 1: downstream accepts the element on this edge when `outValid` is also high.
- `outLast` output, 1: high with `outValid` on element `numNeurons-1`.
- `busy` output, 1: high in STREAM.
- `classIndex` output, `idxWidth`: argmax index of the last completed stream.
- `classValue` output, `dataWidth`: value at `classIndex`.
- `classValid` output, 1: one-cycle pulse when `classIndex`/`classValue` update.

## Operation
- Storage:
  - `buf[0:numNeurons-1]` of `dataWidth` bits.
  - `captured` mask, `numNeurons` bits.
  - Stream index `idx`.
  - Running `maxVal`/`maxIdx`.
- FSM states: COLLECT, STREAM, DONE.
- COLLECT:
  - For each *i* with `inValid[i]` high, `buf[i] <= inData` slice and `captured[i] <= 1`.
  - A repeated valid on an already-captured neuron overwrites its value.
  - When `(captured | inValid)` is all ones at an edge, go to STREAM with `idx <= 0`. The final capture and the transition happen on the same edge.
- STREAM:
  - `outValid = 1`, `outData = buf[idx]`, `outLast = (idx == numNeurons-1)`.
  - `inValid` is ignored and `buf` is frozen.
  - On accept (`outValid && outReady`), update the running argmax:
    - Element 0 loads `maxVal`/`maxIdx` unconditionally.
    - Later elements replace them only if the element is signed-greater than `maxVal`, so ties keep the lowest index.
  - On a non-final accept: `idx <= idx+1`.
  - On the final accept:
    - `classIndex`/`classValue` load the final argmax, including the last element.
    - `classValid <= 1` for one cycle.
    - Go to DONE with `idx <= 0`.
  - While `outValid && !outReady`, `outData`/`outLast` stay stable.
- DONE:
  - Outputs idle and `inValid` is ignored. This prevents re-streaming while neurons hold their valid high.
  - Stay in DONE until `clear`.
- `clear`, any state:
  - Go to COLLECT; `captured <= 0`, `idx <= 0`, `classValid <= 0`.
  - `buf`, `classIndex` and `classValue` are retained.
  - A capture in the same cycle is dropped.
  - Mid-stream `clear` aborts the stream: no further `outValid`, no `outLast`, no `classValid`.
- `reset` values:
  - State COLLECT; `captured`, `idx`, `buf`, `maxVal`, `maxIdx` all 0.
  - Outputs: `outValid=0`, `outLast=0`, `outData=0`, `busy=0`, `classIndex=0`, `classValue=0`, `classValid=0`.

## Timing
- `outValid`/`outData`/`outLast`/`busy` are combinational from registered state and `buf`.
- `classIndex`/`classValue`/`classValid` are registered.
- The last capture at edge T gives `outValid` high in cycle T+1.
- With `outReady` held high, element *k* is presented in cycle T+1+k and `outLast` in cycle T+numNeurons.
- `classValid` is high in cycle T+numNeurons+1.
- `outReady` low inserts stalls one for one; there is no throughput loss beyond the stall.
- A stream never starts in the cycle a `clear` is applied.

## Test plan
All scenarios use `numNeurons=4`, `dataWidth=16`.
- **Simultaneous capture:** all `inValid` high in one cycle, data {0x0100, 0x0400, 0x0200, 0x0000}, `outReady=1`:
  - stream is 0x0100, 0x0400, 0x0200, 0x0000 in 4 consecutive cycles;
  - `outLast` on the 4th;
  - next cycle `classValid=1`, `classIndex=1`, `classValue=0x0400`.
- **Staggered, held valids:** valids rise at cycles 0, 3, 5, 9 and stay high:
  - stream starts at cycle 10;
  - exactly one stream occurs, then DONE with no further `outValid` for 50 cycles.
- **Backpressure:** `outReady` low for 3 cycles while element 2 is presented:
  - `outData` holds element 2 and `outLast=0` throughout;
  - the order is unchanged and the total stream takes 7 cycles.
- **Ties and signed values:** data {0xFC00, 0x0300, 0x0300, 0xFFFF}:
  - `classIndex=1`, `classValue=0x0300`.
- **All negative:** data {0xF000, 0xFE00, 0xF800, 0xFFF0}:
  - `classIndex=3`, `classValue=0xFFF0`.
- **Abort and restart:** `clear` asserted after 2 accepted elements:
  - `outValid` drops the next cycle, with no `outLast` and no `classValid`;
  - re-capturing {1, 2, 3, 4} then streams 1, 2, 3, 4 with `classIndex=3`.
- **Reset mid-stream:** all outputs are 0 the cycle after the edge;
  - a subsequent capture streams normally.

Source files
------------

// File: rtl/layer_output_collector.sv
// layer_output_collector
// Captures one activation per neuron of the producing layer as each neuron
// flags valid, then streams the whole vector out over valid/ready while
// tracking a signed argmax. The argmax of the final element is published on
// classIndex/classValue together with a one-cycle classValid pulse.
module layer_output_collector #(
    parameter int unsigned numNeurons = 32,
    parameter int unsigned dataWidth  = 16,
    parameter int unsigned idxWidth   = $clog2(numNeurons)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic [numNeurons*dataWidth-1:0] inData,
    input  logic [numNeurons-1:0]           inValid,
    output logic [dataWidth-1:0]            outData,
    output logic                            outValid,
    input  logic                            outReady,
    output logic                            outLast,
    output logic                            busy,
    output logic [idxWidth-1:0]             classIndex,
    output logic [dataWidth-1:0]            classValue,
    output logic                            classValid
);

    localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numNeurons - 1);

    typedef enum logic [1:0] {
        COLLECT,
        STREAM,
        DONE
    } state_t;

    state_t                 state_q;
    logic [dataWidth-1:0]   data_q [numNeurons];
    logic [numNeurons-1:0]  captured_q;
    logic [idxWidth-1:0]    idx_q;
    logic [dataWidth-1:0]   maxVal_q;
    logic [idxWidth-1:0]    maxIdx_q;
    logic [idxWidth-1:0]    classIndex_q;
    logic [dataWidth-1:0]   classValue_q;
    logic                   classValid_q;

    logic [dataWidth-1:0]   curElem;
    logic                   isLast;
    logic                   streaming;
    logic                   allCaptured;
    logic [dataWidth-1:0]   maxVal_d;
    logic [idxWidth-1:0]    maxIdx_d;

    assign curElem     = data_q[idx_q];
    assign isLast      = (idx_q == LAST_IDX);
    assign streaming   = (state_q == STREAM);
    assign allCaptured = &(captured_q | inValid);

    // Running argmax including the element currently presented; element 0
    // seeds it, later elements win only when strictly greater (lowest index on ties).
    always_comb begin
        maxVal_d = maxVal_q;
        maxIdx_d = maxIdx_q;
        if ((idx_q == '0) || ($signed(curElem) > $signed(maxVal_q))) begin
            maxVal_d = curElem;
            maxIdx_d = idx_q;
        end
    end

    // Stream-side outputs decode from registered state and the frozen buffer.
    always_comb begin
        outValid = streaming;
        outData  = streaming ? curElem : '0;
        outLast  = streaming && isLast;
        busy     = streaming;
    end

    assign classIndex = classIndex_q;
    assign classValue = classValue_q;
    assign classValid = classValid_q;

    // Capture / stream / done sequencing, buffer writes and argmax registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT;
            captured_q   <= '0;
            idx_q        <= '0;
            maxVal_q     <= '0;
            maxIdx_q     <= '0;
            classIndex_q <= '0;
            classValue_q <= '0;
            classValid_q <= 1'b0;
            for (int unsigned i = 0; i < numNeurons; i++) begin
                data_q[i] <= '0;
            end
        end else if (clear) begin
            // Buffer and last class result are deliberately retained.
            state_q      <= COLLECT;
            captured_q   <= '0;
            idx_q        <= '0;
            classValid_q <= 1'b0;
        end else begin
            classValid_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    for (int unsigned i = 0; i < numNeurons; i++) begin
                        if (inValid[i]) begin
                            data_q[i]     <= inData[i*dataWidth +: dataWidth];
                            captured_q[i] <= 1'b1;
                        end
                    end
                    if (allCaptured) begin
                        state_q <= STREAM;
                        idx_q   <= '0;
                    end
                end
                STREAM: begin
                    if (outReady) begin
                        maxVal_q <= maxVal_d;
                        maxIdx_q <= maxIdx_d;
                        if (isLast) begin
                            classIndex_q <= maxIdx_d;
                            classValue_q <= maxVal_d;
                            classValid_q <= 1'b1;
                            state_q      <= DONE;
                            idx_q        <= '0;
                        end else begin
                            idx_q <= idx_q + idxWidth'(1);
                        end
                    end
                end
                DONE: begin
                    // Held neuron valids must not trigger a second stream.
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_collector.sv
// Bench for layer_output_collector with numNeurons=4, dataWidth=16.
module tb_layer_output_collector;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [N*W-1:0]   inData;
    logic [N-1:0]     inValid;
    logic [W-1:0]     outData;
    logic             outValid;
    logic             outReady;
    logic             outLast;
    logic             busy;
    logic [1:0]       classIndex;
    logic [W-1:0]     classValue;
    logic             classValid;

    int total = 0;
    int bad   = 0;

    layer_output_collector #(
        .numNeurons(N),
        .dataWidth (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .inData    (inData),
        .inValid   (inValid),
        .outData   (outData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outLast   (outLast),
        .busy      (busy),
        .classIndex(classIndex),
        .classValue(classValue),
        .classValid(classValid)
    );

    always #5 clk = ~clk;

    typedef logic [N-1:0][W-1:0] vecdata_t;

    typedef struct {
        vecdata_t    d;
        int unsigned eIdx;
        logic [W-1:0] eVal;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference argmax: first index holding the largest signed value.
    function automatic int unsigned ref_argmax(input vecdata_t d);
        int unsigned best = 0;
        for (int i = 1; i < N; i++)
            if ($signed(d[i]) > $signed(d[best])) best = i;
        return best;
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Simultaneous capture with outReady high; checks exact cycle timing.
    task automatic stream_all(input vecdata_t d, input int unsigned eIdx, input logic [W-1:0] eVal);
        inData   = d;
        inValid  = '1;
        outReady = 1'b1;
        tick();
        inValid = '0;
        for (int k = 0; k < N; k++) begin
            chk("s_valid", 32'(outValid), 32'(1));
            chk("s_busy", 32'(busy), 32'(1));
            chk("s_data", 32'(outData), 32'(d[k]));
            chk("s_last", 32'(outLast), 32'(k == N - 1));
            chk("s_cv_low", 32'(classValid), 32'(0));
            tick();
        end
        chk("c_valid", 32'(classValid), 32'(1));
        chk("c_idx", 32'(classIndex), 32'(eIdx));
        chk("c_val", 32'(classValue), 32'(eVal));
        chk("c_outvalid", 32'(outValid), 32'(0));
        tick();
        chk("c_pulse", 32'(classValid), 32'(0));
        do_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecdata_t d;
        vecdata_t mbuf;
        logic [N-1:0] mcap, v;
        int cyc, k, cnt;
        logic r;
        logic [1:0] prevIdx;

        vecs[0] = '{d: {16'h0000, 16'h0200, 16'h0400, 16'h0100}, eIdx: 1, eVal: 16'h0400};
        vecs[1] = '{d: {16'hFFFF, 16'h0300, 16'h0300, 16'hFC00}, eIdx: 1, eVal: 16'h0300};
        vecs[2] = '{d: {16'hFFF0, 16'hF800, 16'hFE00, 16'hF000}, eIdx: 3, eVal: 16'hFFF0};
        vecs[3] = '{d: {16'h0004, 16'h0003, 16'h0002, 16'h0001}, eIdx: 3, eVal: 16'h0004};
        vecs[4] = '{d: {16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF}, eIdx: 0, eVal: 16'h7FFF};
        vecs[5] = '{d: {16'h0005, 16'h0009, 16'h0001, 16'h0009}, eIdx: 0, eVal: 16'h0009};

        reset = 1'b1; clear = 1'b0; inData = '0; inValid = '0; outReady = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(outValid), 32'(0));
        chk("rst_last", 32'(outLast), 32'(0));
        chk("rst_data", 32'(outData), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cidx", 32'(classIndex), 32'(0));
        chk("rst_cval", 32'(classValue), 32'(0));
        chk("rst_cvalid", 32'(classValid), 32'(0));
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 6; i++)
            stream_all(vecs[i].d, vecs[i].eIdx, vecs[i].eVal);

        // Staggered held valids rising at cycles 0,3,5,9
        d = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        inData = d; outReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) inValid[0] = 1'b1;
            if (c == 3) inValid[1] = 1'b1;
            if (c == 5) inValid[2] = 1'b1;
            if (c == 9) inValid[3] = 1'b1;
            chk("stag_wait", 32'(outValid), 32'(0));
            tick();
        end
        for (int j = 0; j < N; j++) begin
            chk("stag_data", 32'(outData), 32'(d[j]));
            chk("stag_valid", 32'(outValid), 32'(1));
            tick();
        end
        chk("stag_cvalid", 32'(classValid), 32'(1));
        chk("stag_cidx", 32'(classIndex), 32'(3));
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (outValid) cnt++;
            tick();
        end
        chk("stag_done_quiet", 32'(cnt), 32'(0));
        inValid = '0;
        do_clear();

        // Backpressure on element 2
        d = {16'h0D00, 16'h0C00, 16'h0B00, 16'h0A00};
        inData = d; inValid = '1; outReady = 1'b1;
        tick();
        inValid = '0;
        cnt = 0;
        for (int j = 0; j < 7; j++) begin
            outReady = !(j >= 2 && j <= 4);
            k = (j < 2) ? j : (j <= 5 ? 2 : 3);
            chk("bp_valid", 32'(outValid), 32'(1));
            chk("bp_data", 32'(outData), 32'(d[k]));
            chk("bp_last", 32'(outLast), 32'(k == 3));
            if (outValid) cnt++;
            tick();
        end
        chk("bp_cycles", 32'(cnt), 32'(7));
        chk("bp_cvalid", 32'(classValid), 32'(1));
        chk("bp_cidx", 32'(classIndex), 32'(3));
        chk("bp_end", 32'(outValid), 32'(0));
        do_clear();

        // Abort after 2 accepted elements, then restart
        prevIdx = classIndex;
        d = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
        inData = d; inValid = '1; outReady = 1'b1;
        tick();
        inValid = '0;
        tick();
        tick();
        chk("ab_elem2", 32'(outData), 32'(d[2]));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (outValid || outLast || classValid) cnt++;
            tick();
        end
        chk("ab_quiet", 32'(cnt), 32'(0));
        chk("ab_cidx_kept", 32'(classIndex), 32'(prevIdx));
        // clear together with a full capture: the capture is dropped
        inValid = '1; clear = 1'b1;
        tick();
        clear = 1'b0; inValid = '0;
        chk("clr_nostart", 32'(outValid), 32'(0));
        tick();
        chk("clr_dropped", 32'(outValid), 32'(0));
        stream_all(vecs[3].d, 3, 16'h0004);

        // Reset mid-stream
        inData = vecs[0].d; inValid = '1; outReady = 1'b1;
        tick();
        inValid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_valid", 32'(outValid), 32'(0));
        chk("mr_data", 32'(outData), 32'(0));
        chk("mr_last", 32'(outLast), 32'(0));
        chk("mr_busy", 32'(busy), 32'(0));
        chk("mr_cidx", 32'(classIndex), 32'(0));
        chk("mr_cval", 32'(classValue), 32'(0));
        chk("mr_cvalid", 32'(classValid), 32'(0));
        stream_all(vecs[1].d, vecs[1].eIdx, vecs[1].eVal);

        // Randomized inferences against the reference model
        for (int n = 0; n < 25; n++) begin
            mcap = '0; mbuf = '0; cyc = 0;
            while (mcap != '1 && cyc < 100) begin
                v = N'($urandom & $urandom);
                d = {$urandom, $urandom};
                inValid = v; inData = d;
                outReady = 1'($urandom);
                chk("rnd_collect", 32'(outValid), 32'(0));
                tick();
                for (int i = 0; i < N; i++) if (v[i]) mbuf[i] = d[i];
                mcap = mcap | v;
                cyc++;
            end
            if (mcap != '1) chk("rnd_collect_timeout", 32'(mcap), 32'(4'hF));
            k = 0; cyc = 0;
            while (k < N && cyc < 200) begin
                inValid = N'($urandom);
                inData = {$urandom, $urandom};
                r = 1'($urandom);
                outReady = r;
                chk("rnd_valid", 32'(outValid), 32'(1));
                chk("rnd_data", 32'(outData), 32'(mbuf[k]));
                chk("rnd_last", 32'(outLast), 32'(k == N - 1));
                tick();
                if (r) k++;
                cyc++;
            end
            if (k < N) chk("rnd_stream_timeout", 32'(k), 32'(N));
            chk("rnd_cvalid", 32'(classValid), 32'(1));
            chk("rnd_cidx", 32'(classIndex), 32'(ref_argmax(mbuf)));
            chk("rnd_cval", 32'(classValue), 32'(mbuf[ref_argmax(mbuf)]));
            cnt = 0;
            for (int c = 0; c < 4; c++) begin
                inValid = N'($urandom);
                if (outValid) cnt++;
                tick();
            end
            chk("rnd_done_quiet", 32'(cnt), 32'(0));
            inValid = '0;
            do_clear();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
